// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - multicycle mult/div issue, wait and writeback controller
// Holds fetch/decode while the unit runs and buffers its result until the write port is free.
module multdiv_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_dest,
  input  logic [31:0] pipe_data,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t      state, state_next;
  logic [6:0]  count;
  logic [4:0]  rd_q;
  logic        op_div;
  logic        buf_exc;
  logic [31:0] buf_data;
  logic        is_md_op;
  logic        start;
  logic        timeout_hit;

  assign is_md_op    = (opcode == 5'd0) && ((alu_op == 5'b00110) || (alu_op == 5'b00111));
  assign start       = !reset && issue && is_md_op && (state == IDLE);
  assign timeout_hit = (count == 7'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 7'd0;
      rd_q     <= 5'd0;
      op_div   <= 1'b0;
      buf_exc  <= 1'b0;
      buf_data <= 32'd0;
    end else begin
      state <= state_next;
      if (start) begin
        rd_q   <= rd;
        op_div <= alu_op[0];
        count  <= 7'd0;
      end
      if (state == BUSY) begin
        count <= count + 7'd1;
        // md_ready wins over a coinciding timeout
        if (md_ready) begin
          buf_exc  <= md_exception;
          buf_data <= md_result;
        end else if (timeout_hit) begin
          buf_exc  <= 1'b1;
          buf_data <= 32'd0;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    stall      = 1'b0;
    wb_we      = 1'b0;
    wb_dest    = 5'd0;
    wb_data    = 32'd0;
    if (!reset) begin
      ctrl_mult = start && !alu_op[0];
      ctrl_div  = start && alu_op[0];
      stall     = start || (state != IDLE);
      case (state)
        IDLE:    if (start) state_next = BUSY;
        BUSY:    if (md_ready || timeout_hit) state_next = HOLD;
        HOLD:    if (!pipe_we) state_next = IDLE;
        default: state_next = IDLE;
      endcase
      if (pipe_we) begin
        wb_we   = 1'b1;
        wb_dest = pipe_dest;
        wb_data = pipe_data;
      end else if (state == HOLD) begin
        // exceptions report through r30 with a per-op code
        if (buf_exc) begin
          wb_we   = 1'b1;
          wb_dest = 5'd30;
          wb_data = op_div ? 32'd5 : 32'd4;
        end else if (rd_q != 5'd0) begin
          wb_we   = 1'b1;
          wb_dest = rd_q;
          wb_data = buf_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - directed self-checking bench for multdiv_ctrl
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [4:0]  rd;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  logic        pipe_we;
  logic [4:0]  pipe_dest;
  logic [31:0] pipe_data;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  int compared = 0;
  int mismatched = 0;

  multdiv_ctrl #(.TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .issue(issue), .opcode(opcode), .alu_op(alu_op), .rd(rd),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .pipe_we(pipe_we), .pipe_dest(pipe_dest), .pipe_data(pipe_data),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    issue = 0; opcode = 0; alu_op = 0; rd = 0;
    md_result = 0; md_exception = 0; md_ready = 0;
    pipe_we = 0; pipe_dest = 0; pipe_data = 0;
  endtask

  task automatic start_op(input logic is_div, input logic [4:0] dest);
    issue = 1; opcode = 5'd0; alu_op = is_div ? 5'b00111 : 5'b00110; rd = dest;
  endtask

  // issue, wait busy-1 cycles, then pulse md_ready on the busy-th BUSY cycle; returns in HOLD
  task automatic run_to_hold(input logic is_div, input logic [4:0] dest, input int busy,
                             input logic [31:0] res, input logic exc,
                             output logic m_seen, output logic d_seen);
    idle_inputs(); start_op(is_div, dest); #2;
    m_seen = ctrl_mult; d_seen = ctrl_div;
    step(); idle_inputs();
    for (int i = 1; i < busy; i++) step();
    md_ready = 1; md_result = res; md_exception = exc;
    step(); idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); start_op(0, 5'd7);
    pipe_we = 1; pipe_dest = 5'd3; pipe_data = 32'hAA; #2;
    compared++; if (ctrl_mult !== 1'b0) begin mismatched++; $display("FAIL rst_ctrl_mult got %b want 0", ctrl_mult); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rst_stall got %b want 0", stall); end
    compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL rst_wb_we got %b want 0", wb_we); end
    compared++; if (wb_dest !== 5'd0) begin mismatched++; $display("FAIL rst_wb_dest got %0d want 0", wb_dest); end
    compared++; if (wb_data !== 32'd0) begin mismatched++; $display("FAIL rst_wb_data got %h want 0", wb_data); end
    step(); step();
    reset = 0; idle_inputs(); #2;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rst_idle_stall got %b want 0", stall); end
    step();
  endtask

  task automatic test_mul_basic();
    int mp = 0, dp = 0, sc = 0, early = 0;
    for (int c = 1; c <= 18; c++) begin
      idle_inputs(); start_op(0, 5'd7);
      if (c == 17) begin md_ready = 1; md_result = 32'h30; end
      #2;
      mp += int'(ctrl_mult); dp += int'(ctrl_div); sc += int'(stall);
      if (c < 18 && wb_we !== 1'b0) early++;
      if (c == 18) begin
        compared++; if (wb_we !== 1'b1) begin mismatched++; $display("FAIL mul_wb_we got %b want 1", wb_we); end
        compared++; if (wb_dest !== 5'd7) begin mismatched++; $display("FAIL mul_wb_dest got %0d want 7", wb_dest); end
        compared++; if (wb_data !== 32'h30) begin mismatched++; $display("FAIL mul_wb_data got %h want 30", wb_data); end
      end
      step();
    end
    idle_inputs(); #2;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL mul_stall_after got %b want 0", stall); end
    compared++; if (mp != 1) begin mismatched++; $display("FAIL mul_pulses got %0d want 1", mp); end
    compared++; if (dp != 0) begin mismatched++; $display("FAIL mul_div_pulses got %0d want 0", dp); end
    compared++; if (sc != 18) begin mismatched++; $display("FAIL mul_stall_cycles got %0d want 18", sc); end
    compared++; if (early != 0) begin mismatched++; $display("FAIL mul_early_write got %0d want 0", early); end
    step();
  endtask

  task automatic test_div_exc();
    logic m, d;
    run_to_hold(1, 5'd9, 5, 32'h1234, 1, m, d); #2;
    compared++; if (d !== 1'b1 || m !== 1'b0) begin mismatched++; $display("FAIL div_pulse got m=%b d=%b want m=0 d=1", m, d); end
    compared++; if (wb_we !== 1'b1) begin mismatched++; $display("FAIL div_exc_we got %b want 1", wb_we); end
    compared++; if (wb_dest !== 5'd30) begin mismatched++; $display("FAIL div_exc_dest got %0d want 30", wb_dest); end
    compared++; if (wb_data !== 32'd5) begin mismatched++; $display("FAIL div_exc_data got %0d want 5", wb_data); end
    step(); #2;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL div_exc_stall got %b want 0", stall); end
    step();
  endtask

  task automatic test_mul_exc();
    logic m, d;
    run_to_hold(0, 5'd12, 3, 32'hDEAD, 1, m, d); #2;
    compared++; if (m !== 1'b1 || d !== 1'b0) begin mismatched++; $display("FAIL mulx_pulse got m=%b d=%b want m=1 d=0", m, d); end
    compared++; if (wb_we !== 1'b1 || wb_dest !== 5'd30) begin mismatched++; $display("FAIL mulx_dest got we=%b dest=%0d want we=1 dest=30", wb_we, wb_dest); end
    compared++; if (wb_data !== 32'd4) begin mismatched++; $display("FAIL mulx_data got %0d want 4", wb_data); end
    step();
  endtask

  task automatic test_pipe_priority();
    logic m, d;
    run_to_hold(0, 5'd5, 4, 32'h55, 0, m, d);
    for (int k = 0; k < 2; k++) begin
      pipe_we = 1; pipe_dest = 5'd3; pipe_data = 32'hAA; #2;
      compared++; if (wb_we !== 1'b1 || wb_dest !== 5'd3 || wb_data !== 32'hAA) begin mismatched++; $display("FAIL pipe_pri got we=%b dest=%0d data=%h want 1/3/aa", wb_we, wb_dest, wb_data); end
      compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL pipe_pri_stall got %b want 1", stall); end
      step();
    end
    idle_inputs(); #2;
    compared++; if (wb_we !== 1'b1 || wb_dest !== 5'd5 || wb_data !== 32'h55) begin mismatched++; $display("FAIL pipe_buf got we=%b dest=%0d data=%h want 1/5/55", wb_we, wb_dest, wb_data); end
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL pipe_buf_stall got %b want 1", stall); end
    step(); #2;
    compared++; if (stall !== 1'b0 || wb_we !== 1'b0) begin mismatched++; $display("FAIL pipe_done got stall=%b we=%b want 0/0", stall, wb_we); end
    pipe_we = 1; pipe_dest = 5'd17; pipe_data = 32'h1234; #2;
    compared++; if (wb_dest !== 5'd17 || wb_data !== 32'h1234 || stall !== 1'b0) begin mismatched++; $display("FAIL pipe_idle got dest=%0d data=%h stall=%b want 17/1234/0", wb_dest, wb_data, stall); end
    step(); idle_inputs();
  endtask

  task automatic test_timeout();
    int k;
    idle_inputs(); start_op(1, 5'd4); #2; step(); idle_inputs();
    for (k = 1; k <= 200; k++) begin
      #2;
      if (wb_we === 1'b1) break;
      step();
    end
    compared++; if (k != 65) begin mismatched++; $display("FAIL timeout_cycles got %0d want 65", k); end
    compared++; if (wb_dest !== 5'd30 || wb_data !== 32'd5) begin mismatched++; $display("FAIL timeout_wb got dest=%0d data=%0d want 30/5", wb_dest, wb_data); end
    step();
  endtask

  task automatic test_ready_at_timeout();
    logic m, d;
    run_to_hold(0, 5'd6, 64, 32'h77, 0, m, d); #2;
    compared++; if (wb_we !== 1'b1 || wb_dest !== 5'd6 || wb_data !== 32'h77) begin mismatched++; $display("FAIL ready_at_to got we=%b dest=%0d data=%h want 1/6/77", wb_we, wb_dest, wb_data); end
    step();
  endtask

  task automatic test_reset_abort();
    int we_sum = 0, st_sum = 0;
    idle_inputs(); start_op(0, 5'd8); #2; step(); idle_inputs();
    repeat (5) step();
    reset = 1; #2;
    compared++; if (stall !== 1'b0 || wb_we !== 1'b0) begin mismatched++; $display("FAIL abort_rst got stall=%b we=%b want 0/0", stall, wb_we); end
    step();
    reset = 0; md_ready = 1; md_result = 32'h99; #2;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL abort_stall got %b want 0", stall); end
    step(); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #2; we_sum += int'(wb_we); st_sum += int'(stall); step();
    end
    compared++; if (we_sum != 0 || st_sum != 0) begin mismatched++; $display("FAIL abort_after got we=%0d stall=%0d want 0/0", we_sum, st_sum); end
  endtask

  task automatic test_rd_zero();
    logic m, d;
    run_to_hold(0, 5'd0, 2, 32'h11, 0, m, d); #2;
    compared++; if (wb_we !== 1'b0 || wb_dest !== 5'd0 || wb_data !== 32'd0) begin mismatched++; $display("FAIL rd0_wb got we=%b dest=%0d data=%h want 0/0/0", wb_we, wb_dest, wb_data); end
    compared++; if (stall !== 1'b1) begin mismatched++; $display("FAIL rd0_hold_stall got %b want 1", stall); end
    step(); #2;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rd0_idle got %b want 0", stall); end
    issue = 1; opcode = 5'd1; alu_op = 5'b00110; #2;
    compared++; if (stall !== 1'b0 || ctrl_mult !== 1'b0) begin mismatched++; $display("FAIL non_md_op got stall=%b mult=%b want 0/0", stall, ctrl_mult); end
    step(); idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic m, d;
    run_to_hold(1, 5'd2, 1, 32'h42, 0, m, d); #2;
    compared++; if (wb_we !== 1'b1 || wb_dest !== 5'd2 || wb_data !== 32'h42) begin mismatched++; $display("FAIL b2b_first got we=%b dest=%0d data=%h want 1/2/42", wb_we, wb_dest, wb_data); end
    step();
    run_to_hold(0, 5'd3, 2, 32'h43, 0, m, d); #2;
    compared++; if (m !== 1'b1 || wb_dest !== 5'd3 || wb_data !== 32'h43) begin mismatched++; $display("FAIL b2b_second got m=%b dest=%0d data=%h want 1/3/43", m, wb_dest, wb_data); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_mul_basic();
    test_div_exc();
    test_mul_exc();
    test_pipe_priority();
    test_timeout();
    test_ready_at_timeout();
    test_reset_abort();
    test_rd_zero();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
